// File: rtl/drm_metering_event_gen.sv
// Accumulates usage increments into a saturating pending counter and drains it as spaced metering pulses.
// Optional sticky saturation flag output usage_overflow under `METERING_OVERFLOW_FLAG_EN.
module drm_metering_event_gen #(
    parameter int AMT_W     = 8,
    parameter int CNT_W     = 16,
    parameter int EVENT_GAP = 4
) (
    input  logic             drm_aclk,
    input  logic             drm_arstn,
    input  logic             usage_valid,
    output logic             usage_ready,
    input  logic [AMT_W-1:0] usage_amount,
    input  logic [127:0]     activation_code,
    output logic             ip_enable,
    output logic             metering_event,
    output logic [CNT_W-1:0] pending_count
`ifdef METERING_OVERFLOW_FLAG_EN
    ,
    output logic             usage_overflow
`endif
);

    // Sum is wide enough that neither operand can wrap before the clamp.
    localparam int SUM_W = ((CNT_W > AMT_W) ? CNT_W : AMT_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX  = (SUM_W'(1) << CNT_W) - SUM_W'(1);
    localparam logic [7:0]       GAP_LOAD = (EVENT_GAP > 0) ? 8'(EVENT_GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       gap_q, gap_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             ip_enable_q, ip_enable_d;
    logic             event_q, event_d;
    logic             accept;
    logic             dec;
    logic             can_issue;
    logic [SUM_W-1:0] amt_ext;
    logic [SUM_W-1:0] sum;
    logic             code_unused;

    assign code_unused = ^activation_code[127:1];

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        dec         = 1'b0;
        ip_enable_d = activation_code[0];
        accept      = usage_valid && ip_enable_q;
        amt_ext     = accept ? SUM_W'(usage_amount) : '0;
        can_issue   = (pending_q != '0) && ip_enable_q;

        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    state_d = PULSE;
                    dec     = 1'b1;
                end
            end
            PULSE: begin
                if (EVENT_GAP > 0) begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q == 8'd0) begin
                    if (can_issue) begin
                        state_d = PULSE;
                        dec     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // dec only fires with pending_q > 0, so the subtraction cannot underflow.
        sum       = SUM_W'(pending_q) + amt_ext - SUM_W'(dec);
        pending_d = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
        event_d   = (state_d == PULSE);
    end

    always_ff @(posedge drm_aclk or negedge drm_arstn) begin
        if (!drm_arstn) begin
            state_q     <= IDLE;
            gap_q       <= 8'd0;
            pending_q   <= '0;
            ip_enable_q <= 1'b0;
            event_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            pending_q   <= pending_d;
            ip_enable_q <= ip_enable_d;
            event_q     <= event_d;
        end
    end

`ifdef METERING_OVERFLOW_FLAG_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | (accept && (sum > CNT_MAX));
    end

    always_ff @(posedge drm_aclk or negedge drm_arstn) begin
        if (!drm_arstn) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign usage_overflow = overflow_q;
`endif

    assign ip_enable      = ip_enable_q;
    assign usage_ready    = ip_enable_q;
    assign metering_event = event_q;
    assign pending_count  = pending_q;

endmodule
